// File: rtl/tdm_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux_pkg
//  Brief    : Shared types and sizing helpers for the TDM demultiplexer.
//             Frame length depends on macro TDM_DEMUX_PARITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
package tdm_demux_pkg;

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int PARITY_SLOTS = 1;
`else
    localparam int PARITY_SLOTS = 0;
`endif

    // Slot index must be able to hold CHANNELS (the parity slot index).
    function automatic int slot_width(input int channels);
        return $clog2(channels + 1);
    endfunction

    function automatic int frame_len(input int channels);
        return channels + PARITY_SLOTS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_slot_counter
//  Brief    : Wrapping slot counter with clear/load-one/increment controls
//             and a terminal-count flag at LAST.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_slot_counter #(
    parameter int W    = 2,
    parameter int LAST = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         load1_i,
    input  logic         clear_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign tc_o    = (count_q == W'(LAST));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load1_i) begin
            count_d = W'(1);
        end else if (inc_i) begin
            count_d = tc_o ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux
//  Brief    : Time-division demultiplexer rebuilding sync-marked serial slots
//             into a parallel frame word with valid/ready output.
//             Optional trailing parity slot: TDM_DEMUX_PARITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [WIDTH-1:0]                    din,
    input  logic                                din_valid,
    input  logic                                sync,
    output logic [slot_width(CHANNELS)-1:0]     slot,
    output logic [CHANNELS*WIDTH-1:0]           ch_out,
    output logic                                frame_valid,
    input  logic                                frame_ready,
    output logic                                sync_err,
    output logic                                overrun,
    output logic                                parity_err
);

    localparam int SW = slot_width(CHANNELS);
    localparam int FW = CHANNELS * WIDTH;

    state_e        state_q;
    logic [FW-1:0] shadow_q;
    logic [FW-1:0] shadow_d;
    logic [FW-1:0] ch_out_q;
    logic          frame_valid_q;
    logic          sync_err_q;
    logic          overrun_q;
    logic [SW-1:0] slot_q;
    logic          slot_tc;

    logic start;
    logic data_wr;
    logic par_wr;
    logic sync_err_d;
    logic to_hunt;
    logic frame_end;
    logic par_bad;
    logic frame_good;
    logic xfer;

    tdm_slot_counter #(
        .W    (SW),
        .LAST (frame_len(CHANNELS) - 1)
    ) u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (data_wr | par_wr),
        .load1_i (start),
        .clear_i (to_hunt),
        .count_o (slot_q),
        .tc_o    (slot_tc)
    );

    // A sync sample always restarts the frame; mid-frame it also flags an error.
    always_comb begin
        start      = 1'b0;
        data_wr    = 1'b0;
        par_wr     = 1'b0;
        sync_err_d = 1'b0;
        to_hunt    = 1'b0;
        if (din_valid) begin
            if (state_q == ST_HUNT) begin
                start = sync;
            end else if (sync) begin
                start      = 1'b1;
                sync_err_d = (slot_q != '0);
            end else if (slot_q == '0) begin
                sync_err_d = 1'b1;
                to_hunt    = 1'b1;
            end else if (slot_q < SW'(CHANNELS)) begin
                data_wr = 1'b1;
            end else begin
                par_wr = 1'b1;
            end
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        if (start) begin
            shadow_d[WIDTH-1:0] = din;
        end
        for (int k = 1; k < CHANNELS; k++) begin
            if (data_wr && (slot_q == SW'(k))) begin
                shadow_d[k*WIDTH +: WIDTH] = din;
            end
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic par_acc_q;
    logic parity_err_q;

    assign par_bad    = par_wr && (par_acc_q != din[0]);
    assign parity_err = parity_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_acc_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (start) begin
                par_acc_q <= ^din;
            end else if (data_wr) begin
                par_acc_q <= par_acc_q ^ (^din);
            end
            parity_err_q <= par_bad;
        end
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign frame_end  = (data_wr || par_wr) && slot_tc;
    assign frame_good = frame_end && !par_bad;
    assign xfer       = frame_valid_q && frame_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            shadow_q      <= '0;
            ch_out_q      <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_HUNT: if (start)   state_q <= ST_RUN;
                ST_RUN:  if (to_hunt) state_q <= ST_HUNT;
                default:              state_q <= ST_HUNT;
            endcase
            shadow_q   <= shadow_d;
            sync_err_q <= sync_err_d;
            overrun_q  <= 1'b0;
            // A completing frame may load in the same cycle the held one leaves.
            if (frame_good && (!frame_valid_q || frame_ready)) begin
                ch_out_q      <= shadow_d;
                frame_valid_q <= 1'b1;
            end else begin
                if (xfer) begin
                    frame_valid_q <= 1'b0;
                end
                if (frame_good) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign slot        = slot_q;
    assign ch_out      = ch_out_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux
//  Brief    : Scoreboard bench for tdm_demux, CHANNELS=2, WIDTH=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_demux;

    logic       clk;
    logic       rst_n;
    logic [0:0] din;
    logic       din_valid;
    logic       sync;
    logic [1:0] slot;
    logic [1:0] ch_out;
    logic       frame_valid;
    logic       frame_ready;
    logic       sync_err;
    logic       overrun;
    logic       parity_err;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_sync_err = 0;
    int cnt_overrun  = 0;
    int cnt_parity   = 0;

    logic [1:0] exp_q[$];
    logic       prev_hold;
    logic [1:0] prev_ch;

    tdm_demux #(
        .CHANNELS (2),
        .WIDTH    (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .sync        (sync),
        .slot        (slot),
        .ch_out      (ch_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .sync_err    (sync_err),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic d, input logic r);
        din_valid   = v;
        sync        = s;
        din         = d;
        frame_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every transfer, tracks pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0) begin
                    check_value("unexpected_frame", 32'(ch_out), 32'hFFFF_FFFF);
                end else begin
                    check_value("frame_data", 32'(ch_out), 32'(exp_q.pop_front()));
                end
            end
            if (prev_hold) begin
                check_value("hold_stable", 32'(ch_out), 32'(prev_ch));
            end
            prev_hold <= frame_valid && !frame_ready;
            prev_ch   <= ch_out;
            if (sync_err)   cnt_sync_err++;
            if (overrun)    cnt_overrun++;
            if (parity_err) cnt_parity++;
        end else begin
            prev_hold <= 1'b0;
        end
    end

    initial begin
        rst_n = 1'b0;
        step(0, 0, 0, 0);
        step(1, 1, 1, 1);
        check_value("rst_slot", 32'(slot), 32'd0);
        check_value("rst_ch_out", 32'(ch_out), 32'd0);
        check_value("rst_valid", 32'(frame_valid), 32'd0);
        check_value("rst_errs", 32'({sync_err, overrun, parity_err}), 32'd0);
        rst_n = 1'b1;
        step(1, 0, 1, 1);
        step(1, 0, 1, 1);
        check_value("hunt_valid", 32'(frame_valid), 32'd0);
        check_value("hunt_slot", 32'(slot), 32'd0);

`ifdef TDM_DEMUX_PARITY_EN
        exp_q.push_back(2'b11);
        step(1, 1, 1, 1);
        step(1, 0, 1, 1);
        check_value("par_slot2", 32'(slot), 32'd2);
        step(1, 0, 0, 1);
        check_value("par_good_valid", 32'(frame_valid), 32'd1);
        check_value("par_good_err", 32'(parity_err), 32'd0);
        step(1, 1, 1, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        check_value("par_bad_err", 32'(parity_err), 32'd1);
        check_value("par_bad_valid", 32'(frame_valid), 32'd0);
        step(0, 0, 0, 1);
        check_value("par_pulse_cnt", 32'(cnt_parity), 32'd1);
`else
        // Basic frame
        exp_q.push_back(2'b01);
        step(1, 1, 1, 1);
        check_value("basic_slot1", 32'(slot), 32'd1);
        check_value("basic_nv", 32'(frame_valid), 32'd0);
        step(1, 0, 0, 1);
        check_value("basic_slot0", 32'(slot), 32'd0);
        check_value("basic_valid", 32'(frame_valid), 32'd1);
        check_value("basic_ch_out", 32'(ch_out), 32'b01);
        step(0, 0, 0, 1);
        check_value("basic_drained", 32'(frame_valid), 32'd0);

        // Backpressure and overrun
        exp_q.push_back(2'b01);
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        check_value("bp_ch_out_a", 32'(ch_out), 32'b01);
        step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        check_value("bp_overrun", 32'(overrun), 32'd1);
        check_value("bp_ch_out_b", 32'(ch_out), 32'b01);
        step(0, 0, 0, 0);
        check_value("bp_overrun_off", 32'(overrun), 32'd0);
        check_value("bp_overrun_cnt", 32'(cnt_overrun), 32'd1);
        step(0, 0, 0, 1);
        check_value("bp_released", 32'(frame_valid), 32'd0);

        // Mid-frame resync
        exp_q.push_back(2'b10);
        step(1, 1, 1, 1);
        step(1, 1, 0, 1);
        check_value("rs_sync_err", 32'(sync_err), 32'd1);
        check_value("rs_slot", 32'(slot), 32'd1);
        step(1, 0, 1, 1);
        check_value("rs_ch_out", 32'(ch_out), 32'b10);
        check_value("rs_err_off", 32'(sync_err), 32'd0);
        step(0, 0, 0, 1);

        // Missing sync at slot 0 drops back to hunting
        step(1, 0, 1, 1);
        check_value("nosync_err", 32'(sync_err), 32'd1);
        step(1, 0, 1, 1);
        step(1, 0, 0, 1);
        check_value("nosync_valid", 32'(frame_valid), 32'd0);
        check_value("sync_err_cnt", 32'(cnt_sync_err), 32'd2);

        // Stalls, then frame end coinciding with accept
        exp_q.push_back(2'b10);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        check_value("stall_slot", 32'(slot), 32'd1);
        step(1, 0, 1, 0);
        check_value("stall_valid", 32'(frame_valid), 32'd1);
        exp_q.push_back(2'b11);
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);
        step(1, 0, 1, 1);
        check_value("sim_valid", 32'(frame_valid), 32'd1);
        check_value("sim_ch_out", 32'(ch_out), 32'b11);
        check_value("sim_overrun", 32'(overrun), 32'd0);
        step(0, 0, 0, 1);
        check_value("sim_drained", 32'(frame_valid), 32'd0);
        check_value("overrun_total", 32'(cnt_overrun), 32'd1);
`endif

        step(0, 0, 0, 0);
        check_value("queue_empty", 32'(exp_q.size()), 32'd0);
        check_value("parity_total",
`ifdef TDM_DEMUX_PARITY_EN
                    32'(cnt_parity), 32'd1);
`else
                    32'(cnt_parity), 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of the 2:1/N:1 multiplexer path. It accepts a serial stream of samples that an upstream mux has interleaved slot by slot, marked by a frame-sync pulse. It rebuilds each frame into a parallel channel word and hands it downstream over a valid/ready handshake. It also drives the current slot index back so that the mux side can run its select line `S` in lockstep.

## Interface
- `CHANNELS`, default 2: number of data slots per frame; must be ≥2.
- `WIDTH`, default 1: bits per sample, matching the mux data inputs D0/D1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `din`  in  WIDTH  current slot sample.
- `din_valid`  in  1  `din` holds a sample this cycle.
- `sync`  in  1  qualified by `din_valid`; marks the sample as slot 0.
- `slot`  out  clog2(CHANNELS+1)  index of the next slot expected; feeds the mux select.
- `ch_out`  out  CHANNELS*WIDTH  frame word; channel k sits at bits [k*WIDTH +: WIDTH].
- `frame_valid`  out  1  `ch_out` holds an unconsumed frame.
- `frame_ready`  in  1  downstream accepts the frame.
- `sync_err`  out  1  one-cycle pulse: sync arrived mid-frame.
- `overrun`  out  1  one-cycle pulse: completed frame dropped because the output was full.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (see Configuration).

## Operation
- The FSM has 2 states.
  - HUNT is the reset state. It ignores samples until `din_valid && sync`. That sample is stored as slot 0, and the FSM moves to RUN with `slot`=1.
  - RUN: each `din_valid` sample is written to the shadow register at index `slot`, then `slot` increments.
- Frame end comes after the last slot: CHANNELS-1, or CHANNELS when parity is enabled.
  - The shadow register is offered to the output.
  - `slot` wraps to 0. The FSM stays in RUN.
  - The next sample must carry `sync`.
- If `slot`==0 in RUN and the sample arrives without `sync`, then:
  - `sync_err` pulses.
  - The sample is dropped.
  - The FSM returns to HUNT.
- If `sync` arrives with `slot`≠0, then:
  - `sync_err` pulses.
  - The partial frame is discarded.
  - The sample becomes slot 0 and `slot`=1.
- `sync` without `din_valid` is ignored.
- Cycles without `din_valid` stall the slot counter; there is no timeout.
- Output handshake:
  - A frame transfers on any cycle where `frame_valid && frame_ready`.
  - `ch_out` is stable while `frame_valid` is high and `frame_ready` is low.
- Frame end while `frame_valid && !frame_ready`: the new frame is dropped, `overrun` pulses, and the held frame is kept.
- Frame end on the same cycle as an accepted transfer: the new frame loads, `frame_valid` stays 1, and there is no overrun.

## Timing
- Reset values:
  - `slot`=0, `ch_out`=0.
  - `frame_valid`, `sync_err`, `overrun` and `parity_err` all 0.
  - State HUNT; shadow register 0.
- Latency: the cycle after the last slot's sample is accepted, `frame_valid`=1 and `ch_out` is updated.
- `slot` is registered and reflects the accepted samples as of the previous edge.
- All error pulses are registered and assert on the cycle after the offending sample.
- If `rst_n` is asserted mid-frame, all outputs immediately take their reset values and the partial frame is lost. There is no recovery beyond re-hunting for sync.

## Configuration
- `TDM_DEMUX_PARITY_EN` defined:
  - Each frame has CHANNELS+1 slots. The final slot's `din[0]` carries even parity: XOR of all data bits in the frame.
  - On a mismatch, `parity_err` pulses, the frame is discarded, `frame_valid` is unchanged, and the FSM stays in RUN.
  - The `slot` width covers CHANNELS.
- Not defined:
  - Each frame has CHANNELS slots.
  - The `parity_err` port still exists, tied to 0.

## Structure
- Package `tdm_demux_pkg` holds:
  - The state enum: `ST_HUNT`, `ST_RUN`.
  - The helper for the slot-counter width.
  - The frame-length constant, derived from CHANNELS and the macro.
- Sub-module `tdm_slot_counter` holds the wrapping slot counter with `inc`/`load1`/`clear` controls and a terminal-count output.
- The top level holds the FSM, the shadow and output registers, the handshake and the parity logic.

## Test plan
All scenarios use CHANNELS=2 and WIDTH=1.
- **Reset:** hold `rst_n`=0, then release. Then:
  - All outputs are 0 and `slot`=0.
  - With no `sync`, samples 1 and 1 leave `frame_valid` at 0.
- **Basic frame:** (`sync`=1, `din`=1), then `din`=0, with `frame_ready`=1. Then:
  - `ch_out`=2'b01 and `frame_valid`=1 on the next cycle.
  - `slot` sequence is 0→1→0.
- **Backpressure/overrun:** two frames (10 then 11) with `frame_ready`=0. Then:
  - `ch_out` holds 2'b01 throughout.
  - `overrun` pulses once.
  - Raising `frame_ready` clears `frame_valid`.
- **Mid-frame resync:** `sync` with `din`=1, then `sync` with `din`=0, then `din`=1. Then:
  - `sync_err` pulses once.
  - The output frame is 2'b10.
- **Stall and simultaneous transfer:** gaps in `din_valid` between slots. Frame end coincides with the accept of the previous frame. Then:
  - The new frame loads.
  - `frame_valid` stays 1 and `overrun`=0.
- **Parity, with `TDM_DEMUX_PARITY_EN`:** frame 1,1 with parity 0 is accepted. Frame 1,0 with parity 0 gives:
  - A `parity_err` pulse.
  - No new frame.
